// File: rtl/irq_pkg.sv
// Shared widths and types for the interrupt pending latch and its 8:3 encoder.
// IRQ_W must match the encoder input width.
package irq_pkg;

  localparam int IRQ_W     = 8;
  localparam int IRQ_IDX_W = 3;

  typedef logic [IRQ_W-1:0]     irq_vec_t;
  typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

  function automatic irq_vec_t idx_onehot(irq_idx_t idx);
    irq_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/pending/acknowledge bundle between request sources, the latch and the encoder.
// Optional IRQ_OVERRUN_EN adds the sticky overrun vector and its clear strobe.
interface irq_pending_latch_if
  import irq_pkg::*;
#(
  parameter int WIDTH = IRQ_W
);

  logic [WIDTH-1:0] irq_in;
  logic [WIDTH-1:0] mask;
  logic             ack;
  irq_idx_t         ack_idx;
  logic [WIDTH-1:0] pend_out;
  logic             pend_valid;
`ifdef IRQ_OVERRUN_EN
  logic [WIDTH-1:0] overrun;
  logic             overrun_clr;

  modport master (
    output irq_in, mask, ack, ack_idx, overrun_clr,
    input  pend_out, pend_valid, overrun
  );

  modport slave (
    input  irq_in, mask, ack, ack_idx, overrun_clr,
    output pend_out, pend_valid, overrun
  );
`else
  modport master (
    output irq_in, mask, ack, ack_idx,
    input  pend_out, pend_valid
  );

  modport slave (
    input  irq_in, mask, ack, ack_idx,
    output pend_out, pend_valid
  );
`endif

endinterface

// File: rtl/irq_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous request line.
// Latency STAGES clocks; no backpressure.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronises request lines, latches rising-edge events until acked, masks them for the encoder.
// Latency SYNC_STAGES+1 clocks from irq_in to pend_out; no backpressure. Option: IRQ_OVERRUN_EN.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int WIDTH       = IRQ_W,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  irq_pending_latch_if.slave  bus
);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ack_clr;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_n;
  logic [WIDTH-1:0] pend_vis;
  irq_vec_t         ack_oh;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.irq_in[i]),
        .q     (s_q[i])
      );
    end
  endgenerate

  assign rise = s_q & ~s_d;

  // Indices at or above WIDTH fall off the truncated one-hot and are ignored.
  assign ack_oh  = bus.ack ? idx_onehot(bus.ack_idx) : '0;
  assign ack_clr = ack_oh[WIDTH-1:0];

  // Set wins over clear so an event arriving with its own ack is not lost.
  always_comb begin
    pending_n = s_q;
    if (EDGE_MODE != 0) begin
      pending_n = rise | (pending & ~ack_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d     <= '0;
      pending <= '0;
    end else begin
      s_d     <= s_q;
      pending <= pending_n;
    end
  end

  assign pend_vis       = pending & ~bus.mask;
  assign bus.pend_out   = pend_vis;
  assign bus.pend_valid = |pend_vis;

`ifdef IRQ_OVERRUN_EN
  logic [WIDTH-1:0] overrun_q;
  logic [WIDTH-1:0] overrun_set;

  assign overrun_set = (EDGE_MODE != 0) ? (rise & pending & ~ack_clr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_set | (bus.overrun_clr ? '0 : overrun_q);
    end
  end

  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed literal checks plus randomized traffic against an event model.
module tb_irq_pending_latch;
  import irq_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int EM = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_pending_latch_if #(.WIDTH(W)) bus ();

  irq_pending_latch #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(EM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  // Model: hist[n] is the irq_in value sampled n+1 edges ago.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_pend;
  logic [W-1:0] m_ov;
  logic [W-1:0] m_seen, m_prev, m_rise, m_clr;
  logic         m_ovclr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0;
      m_ov   = '0;
      hist.delete();
      for (int k = 0; k <= SS; k++) hist.push_back('0);
    end else begin
      m_seen = hist[SS-1];
      m_prev = hist[SS];
      m_rise = m_seen & ~m_prev;
      m_clr  = (bus.ack && (int'(bus.ack_idx) < W)) ? (W'(1) << bus.ack_idx) : '0;
`ifdef IRQ_OVERRUN_EN
      m_ovclr = bus.overrun_clr;
`else
      m_ovclr = 1'b0;
`endif
      if (EM != 0) begin
        m_ov   = (m_rise & m_pend & ~m_clr) | (m_ovclr ? '0 : m_ov);
        m_pend = m_rise | (m_pend & ~m_clr);
      end else begin
        m_pend = m_seen;
      end
      hist.push_front(bus.irq_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.pend_out !== (m_pend & ~bus.mask)) begin
      errs++;
      $display("FAIL model_pend_out t=%0t got=%h exp=%h", $time, bus.pend_out, m_pend & ~bus.mask);
    end
    checks++;
    if (bus.pend_valid !== |(m_pend & ~bus.mask)) begin
      errs++;
      $display("FAIL model_pend_valid t=%0t got=%b exp=%b", $time, bus.pend_valid, |(m_pend & ~bus.mask));
    end
`ifdef IRQ_OVERRUN_EN
    checks++;
    if (bus.overrun !== m_ov) begin
      errs++;
      $display("FAIL model_overrun t=%0t got=%h exp=%h", $time, bus.overrun, m_ov);
    end
`endif
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int idx);
    bus.ack     = 1'b1;
    bus.ack_idx = irq_idx_t'(idx);
    tick();
    bus.ack     = 1'b0;
  endtask

  initial begin
    bus.irq_in  = '0;
    bus.mask    = '0;
    bus.ack     = 1'b0;
    bus.ack_idx = '0;
`ifdef IRQ_OVERRUN_EN
    bus.overrun_clr = 1'b0;
`endif
    #2;
    tick(2);
    chk("reset_pend_out", bus.pend_out, 8'h00);
    chk("reset_pend_valid", {7'd0, bus.pend_valid}, 8'h00);
    rst_n = 1'b1;
    tick(3);
    chk("idle_pend_out", bus.pend_out, 8'h00);

    // Latency: rise before edge k visible after edge k+2; ack then holds at zero.
    bus.irq_in = 8'h10;
    tick(); chk("lat_k", bus.pend_out, 8'h00);
    tick(); chk("lat_k1", bus.pend_out, 8'h00);
    tick(); chk("lat_k2", bus.pend_out, 8'h10);
    do_ack(4);
    chk("ack4", bus.pend_out, 8'h00);
    tick(3);
    chk("held_high_one_event", bus.pend_out, 8'h00);
    bus.irq_in = 8'h00;
    tick(3);

    bus.irq_in = 8'h81;
    tick(2);
    bus.irq_in = 8'h00;
    tick(3);
    chk("pulse81", bus.pend_out, 8'h81);
    do_ack(7); chk("ack7", bus.pend_out, 8'h01);
    do_ack(7); chk("ack7_again", bus.pend_out, 8'h01);
    do_ack(0); chk("ack0", bus.pend_out, 8'h00);

    bus.irq_in = 8'h04;
    bus.mask   = 8'h04;
    tick(2);
    bus.irq_in = 8'h00;
    tick(3);
    chk("masked_out", bus.pend_out, 8'h00);
    chk("masked_valid", {7'd0, bus.pend_valid}, 8'h00);
    bus.mask = 8'h00;
    #1;
    chk("unmask_same_cycle", bus.pend_out, 8'h04);
    chk("unmask_valid", {7'd0, bus.pend_valid}, 8'h01);
    do_ack(2);
    chk("ack2", bus.pend_out, 8'h00);

    bus.irq_in = 8'h20;
    tick(2);
    bus.irq_in = 8'h00;
    tick(3);
    chk("ch5_pend", bus.pend_out, 8'h20);
    bus.irq_in = 8'h20;
    tick(2);
    do_ack(5);
    chk("rise_with_ack_keeps", bus.pend_out, 8'h20);
`ifdef IRQ_OVERRUN_EN
    chk("no_overrun_on_ack", bus.overrun, 8'h00);
`endif
    bus.irq_in = 8'h00;
    tick(3);
    bus.irq_in = 8'h20;
    tick(4);
    chk("second_rise_pend", bus.pend_out, 8'h20);
`ifdef IRQ_OVERRUN_EN
    chk("overrun_set", bus.overrun, 8'h20);
    tick(2);
    chk("overrun_sticky", bus.overrun, 8'h20);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    chk("overrun_clr", bus.overrun, 8'h00);
`endif
    do_ack(5);
    bus.irq_in = 8'h00;
    tick(3);

    bus.irq_in = 8'h81;
    tick(2);
    bus.irq_in = 8'h00;
    tick(3);
    chk("pre_reset_81", bus.pend_out, 8'h81);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", bus.pend_out, 8'h00);
    chk("async_reset_valid", {7'd0, bus.pend_valid}, 8'h00);

    // Level already high at reset release counts as an event.
    bus.irq_in = 8'hFF;
    tick(2);
    rst_n = 1'b1;
    tick(); chk("rel_e1", bus.pend_out, 8'h00);
    tick(); chk("rel_e2", bus.pend_out, 8'h00);
    tick(); chk("rel_e3", bus.pend_out, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] want;
      want = 8'hFF;
      want = want >> (k + 1);
      do_ack(7 - k);
      chk("ack_walk", bus.pend_out, want);
    end
    bus.irq_in = 8'h00;
    tick(3);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.irq_in = bus.irq_in ^ W'($urandom);
      bus.mask    = W'($urandom & $urandom & $urandom);
      bus.ack     = ($urandom_range(0, 2) == 0);
      bus.ack_idx = irq_idx_t'($urandom_range(0, 7));
`ifdef IRQ_OVERRUN_EN
      bus.overrun_clr = ($urandom_range(0, 15) == 0);
`endif
      if (c == 300) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick();
    end
    bus.ack = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
